// File: rtl/mx_seu_seq.sv
// MX scalar execution unit: accepts one encoded instruction per handshake, executes it
// through IDLE -> EXEC -> WB (shift-add MUL takes WIDTH cycles) and writes one result back.
module mx_seu_seq #(
  parameter int  WIDTH = 8,
  parameter int  NREG  = 16,
  localparam int AW    = $clog2(NREG),
  localparam int IW    = 4 + 3 * AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IW-1:0]         in_instr,
  input  logic [NREG*WIDTH-1:0] reg_line,
  output logic                  wb_en,
  output logic [AW-1:0]         wb_addr,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_XOR = 4'd5,  OP_NOT = 4'd6,  OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8,  OP_MOV = 4'd9,  OP_ADC = 4'd10, OP_SBB = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12, OP_MUL = 4'd13, OP_INC = 4'd14, OP_DEC = 4'd15;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t             state_q;
  logic [3:0]         op_q;
  logic [AW-1:0]      dst_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   res_q;
  logic               resc_q;
  logic               wb_pend_q;
  logic [AW-1:0]      wb_addr_q;
  logic [WIDTH-1:0]   wb_data_q;
  logic               flag_z_q, flag_c_q;

  logic [3:0]         dec_op;
  logic [AW-1:0]      dec_dst, dec_a, dec_b;
  logic [WIDTH-1:0]   opnd_a, opnd_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               op_writes, op_sets_flags, exec_done;

  assign dec_op  = in_instr[IW-1 -: 4];
  assign dec_dst = in_instr[3*AW-1 -: AW];
  assign dec_a   = in_instr[2*AW-1 -: AW];
  assign dec_b   = in_instr[AW-1:0];
  assign opnd_a  = reg_line[dec_a * WIDTH +: WIDTH];
  assign opnd_b  = reg_line[dec_b * WIDTH +: WIDTH];

  // One shift-add step; on the last step this is the full product.
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign exec_done = (op_q != OP_MUL) || (cnt_q == CW'(WIDTH - 1));

  assign op_writes     = (op_q != OP_NOP) && (op_q != OP_CMP);
  assign op_sets_flags = (op_q != OP_NOP) && (op_q != OP_MOV);

  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD:         begin ext = {1'b0, a_q} + {1'b0, b_q};                     alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_ADC:         begin ext = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(flag_c_q); alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_SUB, OP_CMP: begin ext = {1'b0, a_q} - {1'b0, b_q};                     alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_SBB:         begin ext = {1'b0, a_q} - {1'b0, b_q} - (WIDTH+1)'(flag_c_q); alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_INC:         begin ext = {1'b0, a_q} + (WIDTH+1)'(1);                    alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_DEC:         begin ext = {1'b0, a_q} - (WIDTH+1)'(1);                    alu_res = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_AND:         alu_res = a_q & b_q;
      OP_OR:          alu_res = a_q | b_q;
      OP_XOR:         alu_res = a_q ^ b_q;
      OP_NOT:         alu_res = ~a_q;
      OP_SHL:         begin alu_res = {a_q[WIDTH-2:0], 1'b0}; alu_c = a_q[WIDTH-1]; end
      OP_SHR:         begin alu_res = {1'b0, a_q[WIDTH-1:1]}; alu_c = a_q[0]; end
      OP_MOV:         alu_res = a_q;
      OP_MUL:         begin alu_res = acc_sum[WIDTH-1:0]; alu_c = |acc_sum[2*WIDTH-1:WIDTH]; end
      default:        alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_NOP;
      dst_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      resc_q    <= 1'b0;
      wb_pend_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else if (!ce_n) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= dec_op;
            dst_q    <= dec_dst;
            a_q      <= opnd_a;
            b_q      <= opnd_b;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, opnd_a};
            mplier_q <= opnd_b;
            cnt_q    <= '0;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_MUL) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
          end
          if (exec_done) begin
            res_q     <= alu_res;
            resc_q    <= alu_c;
            wb_pend_q <= op_writes;
            if (op_writes) begin
              wb_addr_q <= dst_q;
              wb_data_q <= alu_res;
            end
            state_q <= WB;
          end
        end
        WB: begin
          wb_pend_q <= 1'b0;
          if (op_sets_flags) begin
            flag_z_q <= (res_q == '0);
            flag_c_q <= resc_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake: an instruction transfers on a rising edge where in_valid and in_ready are both 1.
  assign in_ready = (state_q == IDLE) && !ce_n && !rst;
  assign wb_en    = wb_pend_q && !ce_n;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mx_seu_seq.sv
// Bench for mx_seu_seq: directed cases plus randomized instructions checked against an
// arithmetic reference model, with a write-back scoreboard and cycle-accurate latency checks.
module tb_mx_seu_seq;
  localparam int W    = 8;
  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int IW   = 4 + 3 * AW;
  localparam int MOD  = 1 << W;

  logic              clk = 1'b0;
  logic              rst, ce_n, in_valid, in_ready;
  logic [IW-1:0]     in_instr;
  logic [NREG*W-1:0] reg_line;
  logic              wb_en, flag_z, flag_c, busy;
  logic [AW-1:0]     wb_addr;
  logic [W-1:0]      wb_data;

  logic [W-1:0] regs [NREG];
  logic [W-1:0] exp_q [$];
  int checks = 0, failures = 0;
  int exp_z = 0, exp_c = 0;

  mx_seu_seq #(.WIDTH(W), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .ce_n(ce_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .reg_line(reg_line), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    reg_line = '0;
    for (int i = 0; i < NREG; i++) reg_line[i*W +: W] = regs[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: results from plain integer arithmetic on the opcode definitions.
  task automatic model(input int op, input int a, input int b, input int cin,
                       output int res, output int c, output bit wr, output bit fl);
    int s;
    res = 0; c = 0; wr = 1; fl = 1;
    case (op)
      0:  begin wr = 0; fl = 0; end
      1:  begin s = a + b;       res = s % MOD; c = s / MOD; end
      2:  begin res = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  res = (MOD - 1) - a;
      7:  begin res = (a * 2) % MOD; c = a / (MOD / 2); end
      8:  begin res = a / 2; c = a % 2; end
      9:  begin res = a; fl = 0; end
      10: begin s = a + b + cin; res = s % MOD; c = s / MOD; end
      11: begin s = a - b - cin; res = (s + MOD) % MOD; c = (s < 0) ? 1 : 0; end
      12: begin res = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; wr = 0; end
      13: begin s = a * b; res = s % MOD; c = (s >= MOD) ? 1 : 0; end
      14: begin s = a + 1; res = s % MOD; c = s / MOD; end
      default: begin res = (a + MOD - 1) % MOD; c = (a == 0) ? 1 : 0; end
    endcase
  endtask

  // Issue one instruction and follow it to completion. ss/sl: ce_n high for sl cycles
  // starting at cycle ss after accept; rst_at: pulse rst in that cycle (0 = none);
  // hold: keep in_valid asserted with another instruction while the unit is busy.
  task automatic run_op(input int op, input int dst, input int sa, input int sb,
                        input int ss, input int sl, input int rst_at, input bit hold);
    int a, b, res, c, wb_n, busy_n, lat;
    bit wr, fl, done;
    done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) done = 1;
    end
    check("ready_wait", 32'(done), 1);
    if (!done) return;
    in_valid = 1'b1;
    in_instr = {4'(op), 4'(dst), 4'(sa), 4'(sb)};
    a = int'(regs[sa]);
    b = int'(regs[sb]);
    model(op, a, b, exp_c, res, c, wr, fl);
    if (wr) exp_q.push_back(W'(res));
    @(posedge clk); #1;
    in_valid = hold;
    in_instr = {4'd1, 4'd15, 4'd0, 4'd1};
    foreach (regs[i]) regs[i] = W'($urandom);
    wb_n = 0; busy_n = 0; done = 0;
    for (int n = 1; n <= 40 && !done; n++) begin
      ce_n = (n >= ss && n < ss + sl);
      if (n == rst_at) rst = 1'b1;
      @(negedge clk);
      if (wb_en === 1'b1) begin
        wb_n = n;
        if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          check("wb_data", 32'(wb_data), 32'(exp_q.pop_front()));
          check("wb_addr", 32'(wb_addr), 32'(dst));
        end
      end
      if (n == rst_at) begin
        check("rst_wb_en", 32'(wb_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_flags", 32'({flag_z, flag_c}), 0);
        check("rst_wb_out", 32'({wb_addr, wb_data}), 0);
      end
      if (busy === 1'b1) check("ready_busy", 32'(in_ready), 0);
      else begin
        busy_n = n;
        done = 1;
        in_valid = 1'b0;
      end
      if (!done) begin @(posedge clk); #1; end
    end
    ce_n = 1'b0;
    check("op_end", 32'(done), 1);
    if (rst_at > 0) begin
      exp_q.delete();
      exp_z = 0; exp_c = 0;
      check("rst_no_wb", 32'(wb_n), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(in_ready), 1);
      check("flags_after_rst", 32'({flag_z, flag_c}), 0);
    end else begin
      lat = ((op == 13) ? W + 1 : 2) + sl;
      if (wr) check("wb_cycle", 32'(wb_n), 32'(lat));
      else    check("no_wb", 32'(wb_n), 0);
      check("busy_drop", 32'(busy_n), 32'(lat + 1));
      check("wb_pending", 32'(exp_q.size()), 0);
      if (fl) begin exp_z = (res == 0) ? 1 : 0; exp_c = c; end
      check("flag_z", 32'(flag_z), 32'(exp_z));
      check("flag_c", 32'(flag_c), 32'(exp_c));
    end
  endtask

  initial begin
    int op, base, ss, sl, ra;
    rst = 1'b1; ce_n = 1'b0; in_valid = 1'b0; in_instr = '0;
    foreach (regs[i]) regs[i] = '0;

    @(negedge clk);
    check("reset_wb_en", 32'(wb_en), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_ready", 32'(in_ready), 0);
    check("reset_flags", 32'({flag_z, flag_c}), 0);
    check("reset_wb_out", 32'({wb_addr, wb_data}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_release", 32'(in_ready), 1);
    ce_n = 1'b1;
    #1 check("ready_ce_n", 32'(in_ready), 0);
    ce_n = 1'b0;

    regs[0] = 8'hF0; regs[1] = 8'h20; run_op(1, 2, 0, 1, 0, 0, 0, 0);
    regs[4] = 8'h01; regs[5] = 8'h01; run_op(10, 6, 4, 5, 0, 0, 0, 0);
    regs[4] = 8'h00; regs[5] = 8'h01; run_op(11, 6, 4, 5, 0, 0, 0, 0);
    regs[0] = 8'h0F; regs[1] = 8'h11; run_op(13, 3, 0, 1, 0, 0, 0, 0);
    regs[0] = 8'h10; regs[1] = 8'h10; run_op(13, 3, 0, 1, 0, 0, 0, 0);
    regs[0] = 8'h5A; regs[1] = 8'h5A; run_op(12, 0, 0, 1, 0, 0, 0, 0);
    regs[0] = 8'h0F; regs[1] = 8'h11; run_op(13, 3, 0, 1, 3, 3, 0, 0);
    regs[0] = 8'h0F; regs[1] = 8'h11; run_op(13, 3, 0, 1, 0, 0, 4, 0);
    regs[7] = 8'hFF; run_op(14, 7, 7, 7, 0, 0, 0, 0);
    regs[2] = 8'h00; run_op(15, 2, 2, 0, 0, 0, 0, 0);
    regs[3] = 8'h81; run_op(1, 3, 3, 3, 0, 0, 0, 1);
    regs[9] = 8'h33; run_op(1, 9, 9, 9, 0, 0, 2, 0);

    for (int it = 0; it < 80; it++) begin
      foreach (regs[i]) regs[i] = W'($urandom);
      op   = int'($urandom_range(0, 15));
      base = (op == 13) ? W + 1 : 2;
      ss = 0; sl = 0; ra = 0;
      if ($urandom_range(0, 1) == 1) begin
        ss = int'($urandom_range(1, base));
        sl = int'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 9) == 0) begin
        ss = 0; sl = 0;
        ra = int'($urandom_range(1, base));
      end
      run_op(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), ss, sl, ra, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
